// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Post-commit store buffer sitting between the CPU and data memory. Stores are
// queued in a small circular FIFO and drained to memory one per cycle whenever
// memory accepts a write. Loads go straight to memory, but any buffered store
// to the same word overrides the memory data, so a load always sees the
// youngest buffered value for its word.
//
// Parameters
//   W      data and address width
//   DEPTH  number of buffer entries (power of two, 2..16)
//
// Ports
//   clk              single clock, all state updates on its rising edge
//   rst              asynchronous active-low reset, discards every entry
//   s_en             CPU store request
//   s_addr, s_data   store byte address (word aligned) and data
//   s_ready          a store can be accepted this cycle
//   l_en, l_addr     CPU load request and address
//   l_data           load result (forwarded from the buffer or memory data)
//   mem_read_en      data-memory read enable (= l_en)
//   mem_read_addr    data-memory read address (= l_addr)
//   mem_read_data    data-memory read data, valid in the same cycle
//   mem_write_en     data-memory write strobe
//   mem_write_addr   data-memory write address (oldest entry)
//   mem_write_data   data-memory write data (oldest entry)
//   mem_write_ready  memory accepts a write this cycle
//   empty            no valid entries; usable as a drain-complete fence
//   overflow         sticky: a store arrived while the buffer was full
// -----------------------------------------------------------------------------
module store_buffer #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_en,
   input  logic [W-1:0] s_addr,
   input  logic [W-1:0] s_data,
   output logic         s_ready,
   input  logic         l_en,
   input  logic [W-1:0] l_addr,
   output logic [W-1:0] l_data,
   output logic         mem_read_en,
   output logic [W-1:0] mem_read_addr,
   input  logic [W-1:0] mem_read_data,
   output logic         mem_write_en,
   output logic [W-1:0] mem_write_addr,
   output logic [W-1:0] mem_write_data,
   input  logic         mem_write_ready,
   output logic         empty,
   output logic         overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Entry storage (not reset; validity is tracked separately)
   logic [W-1:0]     addr_q [DEPTH];
   logic [W-1:0]     data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;

   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q;

   logic             has_entry;
   logic             push;
   logic             pop;

   logic             fwd_hit;
   logic [W-1:0]     fwd_data;
   logic [PTR_W-1:0] scan_idx;

   // Status derived from registered count only, so s_ready has no path from
   // mem_write_ready: a full buffer refuses a store even while draining.
   assign has_entry = (count_q != '0);
   assign s_ready   = (count_q != FULL_CNT);
   assign empty     = ~has_entry;
   assign overflow  = overflow_q;

   assign push = s_en & s_ready;
   assign pop  = has_entry & mem_write_ready;

   assign mem_write_en   = pop;
   assign mem_write_addr = has_entry ? addr_q[head_q] : '0;
   assign mem_write_data = has_entry ? data_q[head_q] : '0;

   assign mem_read_en   = l_en;
   assign mem_read_addr = l_addr;

   // Control state: pointers, count, valid bits, sticky overflow.
   // Push and pop never target the same slot: a push needs count<DEPTH and a
   // pop needs count>0, so head==tail cannot hold while both happen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         valid_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         if (push) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (s_en && !s_ready) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= s_addr;
         data_q[tail_q] <= s_data;
      end
   end

   // Store-to-load forwarding. Entries are scanned oldest to youngest starting
   // at head, so the last hit is the youngest matching store. Only registered
   // entries are scanned: a store presented this cycle is not yet visible, and
   // the head entry being drained this cycle still forwards.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      scan_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         scan_idx = head_q + PTR_W'(i);
         if (valid_q[scan_idx] && (addr_q[scan_idx][W-1:2] == l_addr[W-1:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[scan_idx];
         end
      end
   end

   assign l_data = fwd_hit ? fwd_data : mem_read_data;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Scoreboard bench for store_buffer. The driver keeps a queue-based model of
// the buffer contents; for each cycle it pushes the expected status, expected
// memory write and expected load result into queues. A monitor on the falling
// edge pops and compares whenever the DUT presents a write or a load.
// -----------------------------------------------------------------------------
module tb_store_buffer;

   localparam int W     = 32;
   localparam int DEPTH = 4;

   logic         clk;
   logic         rst;
   logic         s_en;
   logic [W-1:0] s_addr;
   logic [W-1:0] s_data;
   logic         s_ready;
   logic         l_en;
   logic [W-1:0] l_addr;
   logic [W-1:0] l_data;
   logic         mem_read_en;
   logic [W-1:0] mem_read_addr;
   logic [W-1:0] mem_read_data;
   logic         mem_write_en;
   logic [W-1:0] mem_write_addr;
   logic [W-1:0] mem_write_data;
   logic         mem_write_ready;
   logic         empty;
   logic         overflow;

   store_buffer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .s_en            (s_en),
      .s_addr          (s_addr),
      .s_data          (s_data),
      .s_ready         (s_ready),
      .l_en            (l_en),
      .l_addr          (l_addr),
      .l_data          (l_data),
      .mem_read_en     (mem_read_en),
      .mem_read_addr   (mem_read_addr),
      .mem_read_data   (mem_read_data),
      .mem_write_en    (mem_write_en),
      .mem_write_addr  (mem_write_addr),
      .mem_write_data  (mem_write_data),
      .mem_write_ready (mem_write_ready),
      .empty           (empty),
      .overflow        (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents in program order plus sticky overflow
   logic [W-1:0] m_addr [$];
   logic [W-1:0] m_data [$];
   bit           m_ovf;

   // Scoreboard queues
   logic [3:0]     sq [$];   // {s_ready, empty, mem_write_en, overflow}
   logic [2*W-1:0] wq [$];   // {addr, data} of expected memory writes
   logic [2*W-1:0] lq [$];   // {load addr, expected l_data}

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus: apply inputs, record expectations, advance model
   task automatic cycle(input bit se, input logic [W-1:0] sa, input logic [W-1:0] sd,
                        input bit le, input logic [W-1:0] la, input logic [W-1:0] rd,
                        input bit wr);
      bit           e_ready, e_empty, e_wen;
      logic [W-1:0] fwd, qa;
      @(posedge clk);
      #1;
      s_en            = se;
      s_addr          = sa;
      s_data          = sd;
      l_en            = le;
      l_addr          = la;
      mem_read_data   = rd;
      mem_write_ready = wr;

      e_ready = (m_addr.size() != DEPTH);
      e_empty = (m_addr.size() == 0);
      e_wen   = (m_addr.size() > 0) && wr;
      sq.push_back({e_ready, e_empty, e_wen, m_ovf});
      if (e_wen) wq.push_back({m_addr[0], m_data[0]});
      if (le) begin
         fwd = rd;
         for (int i = 0; i < m_addr.size(); i++) begin
            qa = m_addr[i];
            if (qa[W-1:2] == la[W-1:2]) fwd = m_data[i];
         end
         lq.push_back({la, fwd});
      end

      if (e_wen) begin
         void'(m_addr.pop_front());
         void'(m_data.pop_front());
      end
      if (se) begin
         if (e_ready) begin
            m_addr.push_back(sa);
            m_data.push_back(sd);
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic idle(input bit wr);
      cycle(1'b0, '0, '0, 1'b0, '0, $urandom, wr);
   endtask

   task automatic drain();
      int n = 0;
      while (m_addr.size() > 0 && n < 32) begin
         idle(1'b1);
         n++;
      end
      if (m_addr.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d required=0", m_addr.size());
      end
      idle(1'b1);
   endtask

   // Monitor: compares DUT outputs against queued expectations
   logic [3:0]     st;
   logic [2*W-1:0] we;
   logic [2*W-1:0] le_exp;
   always @(negedge clk) begin
      if (sq.size() > 0) begin
         st = sq.pop_front();
         chk1("s_ready",      s_ready,      st[3]);
         chk1("empty",        empty,        st[2]);
         chk1("mem_write_en", mem_write_en, st[1]);
         chk1("overflow",     overflow,     st[0]);
      end
      if (mem_write_en) begin
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual_addr=%h required=no_write", mem_write_addr);
         end else begin
            we = wq.pop_front();
            chk("wr_addr", mem_write_addr, we[2*W-1:W]);
            chk("wr_data", mem_write_data, we[W-1:0]);
         end
      end
      if (l_en) begin
         if (lq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load actual_addr=%h required=none", l_addr);
         end else begin
            le_exp = lq.pop_front();
            chk1("mem_read_en",  mem_read_en,   1'b1);
            chk("mem_read_addr", mem_read_addr, le_exp[2*W-1:W]);
            chk("l_data",        l_data,        le_exp[W-1:0]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit           se, le, wr;
      logic [W-1:0] sa, la;
      rst = 1'b1; s_en = 1'b0; s_addr = '0; s_data = '0; l_en = 1'b0; l_addr = '0;
      mem_read_data = '0; mem_write_ready = 1'b1; m_ovf = 1'b0;
      #1 rst = 1'b0;
      #2;
      chk1("rst_s_ready",  s_ready,      1'b1);
      chk1("rst_empty",    empty,        1'b1);
      chk1("rst_wen",      mem_write_en, 1'b0);
      chk1("rst_overflow", overflow,     1'b0);
      #14 rst = 1'b1;

      // Single store, drains the cycle after it is accepted
      cycle(1'b1, 32'h10, 32'hAAAA, 1'b0, '0, '0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Forwarding: youngest of two matching stores, then a non-matching word
      cycle(1'b1, 32'h20, 32'h1, 1'b0, '0, '0, 1'b0);
      cycle(1'b1, 32'h20, 32'h2, 1'b0, '0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 32'h20, 32'h99, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 32'h24, 32'h99, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 32'h23, 32'h99, 1'b0);
      // Same-cycle store not forwarded; draining entry still forwards
      cycle(1'b1, 32'h40, 32'h55, 1'b1, 32'h40, 32'h77, 1'b1);
      cycle(1'b0, '0, '0, 1'b1, 32'h20, 32'h77, 1'b1);
      drain();

      // Fill, overflow, ordered drain
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'(i * 4), 32'(100 + i), 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 5; i++) idle(1'b1);

      // Full with concurrent drain: store still refused, accepted next cycle
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h80 + 32'(i * 4), 32'(200 + i), 1'b0, '0, '0, 1'b0);
      cycle(1'b1, 32'h90, 32'h300, 1'b0, '0, '0, 1'b1);
      cycle(1'b1, 32'h94, 32'h301, 1'b0, '0, '0, 1'b0);
      drain();

      // Randomised traffic on a small address set to provoke forwarding hits
      for (int n = 0; n < 400; n++) begin
         se = ($urandom_range(0, 2) != 0);
         le = ($urandom_range(0, 1) != 0);
         wr = ($urandom_range(0, 3) == 0) ? 1'b0 : ($urandom_range(0, 1) != 0);
         sa = 32'($urandom_range(0, 7)) << 2;
         la = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         cycle(se, sa, $urandom, le, la, $urandom, wr);
      end
      drain();

      // Reset in the middle of a cycle with three stores pending
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC0 + 32'(i * 4), 32'(500 + i), 1'b0, '0, '0, 1'b0);
      @(posedge clk);
      #2;
      s_en = 1'b0;
      l_en = 1'b0;
      mem_write_ready = 1'b1;
      rst = 1'b0;
      #1;
      chk1("midrst_wen",      mem_write_en, 1'b0);
      chk1("midrst_empty",    empty,        1'b1);
      chk1("midrst_s_ready",  s_ready,      1'b1);
      chk1("midrst_overflow", overflow,     1'b0);
      m_addr.delete();
      m_data.delete();
      m_ovf = 1'b0;
      #4 rst = 1'b1;
      for (int i = 0; i < 6; i++) idle(1'b1);
      cycle(1'b1, 32'hE0, 32'h1234, 1'b1, 32'hC0, 32'h4321, 1'b1);
      drain();

      @(posedge clk);
      #6;
      chk("scoreboard_left", W'(sq.size() + wq.size() + lq.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
